smi_flit_narrow_stage_x2: RTL

- Single SMI flit width reduction stage; the inverse of the x2 width expansion stage.
- Accepts flits of 2*FlitWidth bytes and emits each as up to two flits of FlitWidth bytes, low half first.
- Preserves frame boundaries through end of frame control (eofc) rewriting.
- Cascaded stages narrow by 4, 8, and so on, on the path from wide kernel buses to narrow SMI links.

---
 rtl/smi_flit_narrow_stage_x2_if.sv | 13 +
 rtl/smi_flit_narrow_stage_x2.sv | 86 ++++++++
 2 files changed

// File: rtl/smi_flit_narrow_stage_x2_if.sv
// SMI flit bus: one flit transfers on a rising edge where ready=1 and stop=0.
// The sender drives ready/eofc/data and holds them stable while stop=1.
interface smi_flit_narrow_stage_x2_if #(
    parameter int unsigned DataBytes = 4
);
    logic                   ready;
    logic [7:0]             eofc;
    logic [DataBytes*8-1:0] data;
    logic                   stop;

    modport master (output ready, eofc, data, input stop);
    modport slave  (input ready, eofc, data, output stop);
endinterface

// File: rtl/smi_flit_narrow_stage_x2.sv
// Halves SMI flit width: each 2*FlitWidth-byte input flit leaves as up to two
// FlitWidth-byte flits, low half first, with eofc rewritten so frame ends are kept.
module smi_flit_narrow_stage_x2 #(
    parameter int unsigned FlitWidth = 4,
    parameter int unsigned EofcMask  = 4 * FlitWidth - 1
) (
    input  logic                              clk,
    input  logic                              srst,
    smi_flit_narrow_stage_x2_if.slave         smiIn,
    smi_flit_narrow_stage_x2_if.master        smiOut
);
    localparam int unsigned W         = FlitWidth * 8;
    localparam logic [7:0]  FlitBytes = 8'(FlitWidth);
    localparam logic [7:0]  MaskBits  = 8'(EofcMask);

    typedef enum logic {PhLow, PhHigh} phase_t;

    logic           inReady_q;
    logic [7:0]     inEofc_q;
    logic [2*W-1:0] inData_q;
    phase_t         phase_q;
    logic           outReady_q;
    logic [7:0]     outEofc_q;
    logic [W-1:0]   outData_q;

    logic           outLoadable;
    logic           emit;
    logic           nextHigh;
    logic           inHalt;
    logic           inStop;
    logic [7:0]     emitEofc;
    logic [W-1:0]   emitData;

    always_comb begin
        emitData = inData_q[W-1:0];
        emitEofc = inEofc_q;
        nextHigh = 1'b0;
        if (phase_q == PhHigh) begin
            emitData = inData_q[2*W-1:W];
            emitEofc = (inEofc_q == 8'd0) ? 8'd0 : inEofc_q - FlitBytes;
        end else if (inEofc_q == 8'd0 || inEofc_q > FlitBytes) begin
            // Flit continues into the high half: hold the input register one more cycle.
            emitEofc = 8'd0;
            nextHigh = 1'b1;
        end
        outLoadable = !(outReady_q && smiOut.stop);
        emit        = inReady_q && outLoadable;
        inHalt      = !outLoadable || (emit && nextHigh);
        inStop      = inReady_q && inHalt;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            inReady_q  <= 1'b0;
            phase_q    <= PhLow;
            outReady_q <= 1'b0;
        end else begin
            if (!inStop) begin
                inReady_q <= smiIn.ready;
            end
            if (outLoadable) begin
                outReady_q <= emit;
                if (emit) begin
                    phase_q <= nextHigh ? PhHigh : PhLow;
                end
            end
        end
    end

    // Payload registers carry no reset; they are qualified by the ready bits.
    always_ff @(posedge clk) begin
        if (!inStop) begin
            inEofc_q <= smiIn.eofc & MaskBits;
            inData_q <= smiIn.data;
        end
        if (emit) begin
            outEofc_q <= emitEofc;
            outData_q <= emitData;
        end
    end

    assign smiIn.stop   = inStop;
    assign smiOut.ready = outReady_q;
    assign smiOut.eofc  = outEofc_q;
    assign smiOut.data  = outData_q;
endmodule
